receipt_ctrl: RTL and testbench



---
 rtl/receipt_ctrl.sv | 147 ++++++++++++++
 tb/tb_receipt_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/receipt_ctrl.sv
// rtl/receipt_ctrl.sv - receipt RAM sequencer: appends bytes, streams them out on print, then empties.
// Optional RECEIPT_CHECKSUM_EN appends a mod-256 sum byte after the data bytes.
module receipt_ctrl #(
  parameter int AW    = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          add_valid,
  input  logic [DW-1:0] add_data,
  output logic          add_ready,
  input  logic          print_start,
  input  logic          clear,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_write,
  input  logic [DW-1:0] ram_rdata,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          busy,
  output logic          done
);

`ifdef RECEIPT_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LATCH, S_PRESENT, S_DONE, S_CSUM} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_LATCH, S_PRESENT, S_DONE} state_t;
`endif

  state_t        r_state;
  state_t        w_next_state;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [DW-1:0] r_out_data;
  logic          w_full;
  logic          w_last;
  logic          w_add_fire;
`ifdef RECEIPT_CHECKSUM_EN
  logic [DW-1:0] r_sum;
`endif

  assign w_full = (r_count == (AW+1)'(DEPTH));
  // Last byte when the next read pointer would reach the stored count.
  assign w_last = (({1'b0, r_rd_ptr} + (AW+1)'(1)) >= r_count);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    add_ready    = 1'b0;
    w_add_fire   = 1'b0;
    ram_write    = 1'b0;
    ram_addr     = r_rd_ptr;
    ram_wdata    = add_data;
    case (r_state)
      S_IDLE: begin
        ram_addr   = r_count[AW-1:0];
        add_ready  = !w_full && !print_start && !clear;
        w_add_fire = add_valid && !w_full && !print_start && !clear;
        ram_write  = w_add_fire;
        if (print_start) w_next_state = (r_count != '0) ? S_ISSUE : S_DONE;
      end
      S_ISSUE: w_next_state = S_LATCH;
      S_LATCH: w_next_state = S_PRESENT;
      S_PRESENT: begin
        if (out_ready) begin
          if (!w_last) w_next_state = S_ISSUE;
`ifdef RECEIPT_CHECKSUM_EN
          else         w_next_state = S_CSUM;
`else
          else         w_next_state = S_DONE;
`endif
        end
      end
`ifdef RECEIPT_CHECKSUM_EN
      S_CSUM: if (out_ready) w_next_state = S_DONE;
`endif
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_out_data <= '0;
`ifdef RECEIPT_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (print_start) begin
            r_rd_ptr <= '0;
          end else if (clear) begin
            r_count <= '0;
`ifdef RECEIPT_CHECKSUM_EN
            r_sum   <= '0;
`endif
          end else if (w_add_fire) begin
            r_count <= r_count + (AW+1)'(1);
`ifdef RECEIPT_CHECKSUM_EN
            r_sum   <= r_sum + add_data;
`endif
          end
        end
        S_LATCH: r_out_data <= ram_rdata;
        S_PRESENT: begin
          if (out_ready && !w_last) r_rd_ptr <= r_rd_ptr + AW'(1);
`ifdef RECEIPT_CHECKSUM_EN
          if (out_ready && w_last) r_out_data <= r_sum;
`endif
        end
        S_DONE: begin
          r_count  <= '0;
          r_rd_ptr <= '0;
`ifdef RECEIPT_CHECKSUM_EN
          r_sum    <= '0;
`endif
        end
        default: ;
      endcase
    end
  end

`ifdef RECEIPT_CHECKSUM_EN
  assign out_valid = (r_state == S_PRESENT) || (r_state == S_CSUM);
`else
  assign out_valid = (r_state == S_PRESENT);
`endif
  assign out_data = r_out_data;
  assign count    = r_count;
  assign full     = w_full;
  assign empty    = (r_count == '0);
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);

endmodule

// File: tb/tb_receipt_ctrl.sv
// tb/tb_receipt_ctrl.sv - directed bench for receipt_ctrl with a behavioural 16x8 RAM.
module tb_receipt_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          add_valid = 1'b0;
  logic [DW-1:0] add_data = '0;
  logic          add_ready;
  logic          print_start = 1'b0;
  logic          clear = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_write;
  logic [DW-1:0] ram_rdata = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [AW:0]   count;
  logic          full, empty, busy, done;

  receipt_ctrl #(.AW(AW), .DW(DW), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .add_valid(add_valid), .add_data(add_data), .add_ready(add_ready),
    .print_start(print_start), .clear(clear), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_write(ram_write), .ram_rdata(ram_rdata), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_wdata;
    else           ram_rdata <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_bytes[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  typedef struct {
    logic        av;
    logic [7:0]  ad;
    logic        ps;
    logic        clr;
    logic        ordy;
    logic [21:0] exp;
  } vec_t;

  function automatic logic [21:0] ex(input logic ardy, input logic wr, input logic [3:0] addr,
                                     input logic ov, input logic [7:0] od, input logic [4:0] cnt,
                                     input logic bsy, input logic dn);
    return {ardy, wr, addr, ov, od, cnt, bsy, dn};
  endfunction

  function automatic vec_t mkv(input logic av, input logic [7:0] ad, input logic ps,
                               input logic clr, input logic ordy, input logic [21:0] e);
    vec_t v;
    v.av = av; v.ad = ad; v.ps = ps; v.clr = clr; v.ordy = ordy; v.exp = e;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic append(input logic [7:0] b, input int idx);
    add_valid = 1'b1;
    add_data  = b;
    @(negedge clk);
    chk("append_ready", add_ready, 1'b1);
    chk("append_write", ram_write, 1'b1);
    chk("append_addr", ram_addr, idx[3:0]);
    chk("append_wdata", ram_wdata, b);
    next_cycle();
    add_valid = 1'b0;
  endtask

  task automatic run_print(input string tag, input bit toggle, input bit with_add);
    logic [7:0] got[$];
    int first_v = -1;
    int done_cyc = -1;
    int last_hs = -1;
    bit stalled = 1'b0;
    logic [7:0] held = '0;
    for (int k = 0; k < 300 && done_cyc < 0; k++) begin
      print_start = (k == 0);
      add_valid   = (k == 0) && with_add;
      add_data    = 8'hAA;
      out_ready   = toggle ? (k % 2 == 1) : 1'b1;
      @(negedge clk);
      if (k == 0 && with_add) begin
        chk({tag, "_collide_write"}, ram_write, 1'b0);
        chk({tag, "_collide_ready"}, add_ready, 1'b0);
      end
      if (stalled) begin
        chk({tag, "_stall_valid"}, out_valid, 1'b1);
        chk({tag, "_stall_data"}, out_data, held);
      end
      if (out_valid && first_v < 0) first_v = k;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        last_hs = k;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (done) done_cyc = k;
      next_cycle();
    end
    print_start = 1'b0;
    add_valid   = 1'b0;
    out_ready   = 1'b0;
    chk({tag, "_done_seen"}, done_cyc >= 0, 1'b1);
    if (exp_bytes.size() > 0) begin
      chk({tag, "_first_latency"}, first_v, 3);
      chk({tag, "_done_after_last"}, done_cyc, last_hs + 1);
    end else begin
      chk({tag, "_no_valid"}, first_v, -1);
      chk({tag, "_done_latency"}, done_cyc, 1);
    end
    chk({tag, "_nbytes"}, got.size(), exp_bytes.size());
    for (int i = 0; i < exp_bytes.size() && i < got.size(); i++)
      chk({tag, "_byte"}, got[i], exp_bytes[i]);
    @(negedge clk);
    chk({tag, "_done_once"}, done, 1'b0);
    chk({tag, "_idle_after"}, {busy, count, empty}, {1'b0, 5'd0, 1'b1});
    next_cycle();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = mkv(0, 8'h00, 0, 0, 0, ex(1, 0, 4'd0, 0, 8'h00, 5'd0, 0, 0));
    vecs[1] = mkv(1, 8'h11, 0, 0, 0, ex(1, 1, 4'd0, 0, 8'h00, 5'd0, 0, 0));
    vecs[2] = mkv(1, 8'h22, 0, 0, 0, ex(1, 1, 4'd1, 0, 8'h00, 5'd1, 0, 0));
    vecs[3] = mkv(1, 8'h33, 0, 0, 0, ex(1, 1, 4'd2, 0, 8'h00, 5'd2, 0, 0));
    vecs[4] = mkv(0, 8'h00, 0, 0, 0, ex(1, 0, 4'd3, 0, 8'h00, 5'd3, 0, 0));
    vecs[5] = mkv(1, 8'h44, 0, 1, 0, ex(0, 0, 4'd3, 0, 8'h00, 5'd3, 0, 0));
    vecs[6] = mkv(0, 8'h00, 0, 0, 0, ex(1, 0, 4'd0, 0, 8'h00, 5'd0, 0, 0));
    vecs[7] = mkv(0, 8'h00, 1, 0, 0, ex(0, 0, 4'd0, 0, 8'h00, 5'd0, 0, 0));
    vecs[8] = mkv(0, 8'h00, 0, 0, 0, ex(0, 0, 4'd0, 0, 8'h00, 5'd0, 1, 1));
    vecs[9] = mkv(0, 8'h00, 0, 0, 0, ex(1, 0, 4'd0, 0, 8'h00, 5'd0, 0, 0));

    rst = 1'b1;
    repeat (2) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_flags", {empty, full, busy, out_valid, done}, 5'b10000);
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      add_valid   = vecs[i].av;
      add_data    = vecs[i].ad;
      print_start = vecs[i].ps;
      clear       = vecs[i].clr;
      out_ready   = vecs[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          {add_ready, ram_write, ram_addr, out_valid, out_data, count, busy, done}, vecs[i].exp);
      next_cycle();
    end
    add_valid = 1'b0; print_start = 1'b0; clear = 1'b0;

    append(8'h11, 0); append(8'h22, 1); append(8'h33, 2);
    @(negedge clk);
    chk("three_count", count, 5'd3);
    next_cycle();
    exp_bytes = '{8'h11, 8'h22, 8'h33};
`ifdef RECEIPT_CHECKSUM_EN
    exp_bytes.push_back(8'h66);
`endif
    run_print("print3", 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) append(8'(i), i);
    add_valid = 1'b1;
    add_data  = 8'hEE;
    @(negedge clk);
    chk("full_flag", full, 1'b1);
    chk("full_ready", add_ready, 1'b0);
    chk("full_nowrite", ram_write, 1'b0);
    next_cycle();
    add_valid = 1'b0;
    @(negedge clk);
    chk("full_count", count, 5'd16);
    next_cycle();
    exp_bytes.delete();
    for (int i = 0; i < 16; i++) exp_bytes.push_back(8'(i));
`ifdef RECEIPT_CHECKSUM_EN
    exp_bytes.push_back(8'h78);
`endif
    run_print("print16", 1'b1, 1'b0);

    append(8'hA1, 0); append(8'hA2, 1);
    exp_bytes = '{8'hA1, 8'hA2};
`ifdef RECEIPT_CHECKSUM_EN
    exp_bytes.push_back(8'h43);
`endif
    run_print("collide", 1'b0, 1'b1);

    exp_bytes.delete();
    run_print("empty", 1'b0, 1'b0);

    append(8'hC1, 0); append(8'hC2, 1); append(8'hC3, 2); append(8'hC4, 3);
    print_start = 1'b1;
    out_ready   = 1'b0;
    next_cycle();
    print_start = 1'b0;
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge clk);
        if (out_valid) seen = 1'b1;
        else next_cycle();
      end
      chk("rst_mid_reach_present", seen, 1'b1);
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_state", {busy, count, out_valid, out_data, empty}, {1'b0, 5'd0, 1'b0, 8'h00, 1'b1});
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
